// File: rtl/sha2_256_core_param.sv
// SHA-256 / SHA-224 compression engine with 1, 2 or 4 rounds per clock, valid/ready
// on block input and digest output, and internal chaining across multi-block messages.
module sha2_256_core_param #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter bit SUPPORT_224      = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] block_in,
  input  logic         first_block,
  input  logic         last_block,
  input  logic         mode_224,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] digest_out,
  output logic         busy
);

  if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 4)) begin : g_bad_rpc
    $error("ROUNDS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {IDLE, COMP, FINAL, OUT} state_t;

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    logic [63:0] d;
    d = {x, x} >> n;
    return d[31:0];
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  state_t        state, state_nx;
  logic [31:0]   hreg [8];
  logic [31:0]   v    [8];   // working variables a..h
  logic [31:0]   w    [16];  // circular schedule buffer, index = t mod 16
  logic [5:0]    t;
  logic          mode, last_q, out_valid_q;
  logic [255:0]  digest_q;

  logic [31:0]   iv_sel [8];
  logic [31:0]   wb [16];
  logic [31:0]   vb [8];
  logic [31:0]   wt, t1, t2;
  logic [6:0]    ti;
  logic [3:0]    ix;

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx = state;
    in_ready = 1'b0;
    busy     = (state != IDLE);
    unique case (state)
      IDLE:  begin
        in_ready = 1'b1;
        if (in_valid) state_nx = COMP;
      end
      COMP:  if (t == 6'(64 - ROUNDS_PER_CYCLE)) state_nx = FINAL;
      FINAL: state_nx = last_q ? OUT : IDLE;
      OUT:   if (out_valid_q && out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 8; i++)
      iv_sel[i] = (mode_224 && SUPPORT_224) ? IV224[i] : IV256[i];
  end

  // Rounds t..t+R-1 chained combinationally; later rounds see schedule words written by earlier ones.
  // NOTE: blocking assignments here are intentional: each loop iteration must see the previous one's result.
  always_comb begin
    wb = w;
    vb = v;
    wt = '0;
    t1 = '0;
    t2 = '0;
    ti = '0;
    ix = '0;
    for (int k = 0; k < ROUNDS_PER_CYCLE; k++) begin
      ti = 7'(t) + 7'(k);
      ix = ti[3:0];
      if (ti >= 7'd16)
        wb[ix] = ssig1(wb[ix - 4'd2]) + wb[ix - 4'd7] + ssig0(wb[ix - 4'd15]) + wb[ix];
      wt = wb[ix];
      t1 = vb[7] + bsig1(vb[4]) + ((vb[4] & vb[5]) ^ (~vb[4] & vb[6])) + K[ti[5:0]] + wt;
      t2 = bsig0(vb[0]) + ((vb[0] & vb[1]) ^ (vb[0] & vb[2]) ^ (vb[1] & vb[2]));
      vb[7] = vb[6];
      vb[6] = vb[5];
      vb[5] = vb[4];
      vb[4] = vb[3] + t1;
      vb[3] = vb[2];
      vb[2] = vb[1];
      vb[1] = vb[0];
      vb[0] = t1 + t2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      t           <= '0;
      mode        <= 1'b0;
      last_q      <= 1'b0;
      out_valid_q <= 1'b0;
      digest_q    <= '0;
      // NOTE: the schedule buffer is reset too, so an aborted block leaves no residue behind.
      for (int i = 0; i < 16; i++) w[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        hreg[i] <= '0;
        v[i]    <= '0;
      end
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: if (in_valid) begin
          for (int i = 0; i < 16; i++) w[i] <= block_in[511 - 32*i -: 32];
          last_q <= last_block;
          t      <= '0;
          if (first_block) begin
            mode <= mode_224 & SUPPORT_224;
            for (int i = 0; i < 8; i++) begin
              hreg[i] <= iv_sel[i];
              v[i]    <= iv_sel[i];
            end
          end else begin
            v <= hreg;
          end
        end
        COMP: begin
          w <= wb;
          v <= vb;
          t <= t + 6'(ROUNDS_PER_CYCLE);
        end
        FINAL: for (int i = 0; i < 8; i++) hreg[i] <= hreg[i] + v[i];
        OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            digest_q    <= {hreg[0], hreg[1], hreg[2], hreg[3], hreg[4], hreg[5], hreg[6],
                            mode ? 32'h0 : hreg[7]};
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid  = out_valid_q;
  assign digest_out = digest_q;

endmodule

// File: tb/tb_sha2_256_core_param.sv
// Directed bench: four cores (R=1, R=2, R=4, R=1 without SHA-224) share one stimulus
// stream and are checked against known SHA-256/224 digests and latencies.
module tb_sha2_256_core_param;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {
    32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
    32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
    32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
    32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};

  localparam logic [255:0] D_ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_ABC224 = 256'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da700000000;
  localparam logic [255:0] D_TWO    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_EMPTY  = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;

  localparam int LAT [4] = '{66, 34, 18, 66};

  logic         clk, rst, in_valid, first_block, last_block, mode_224, out_ready;
  logic [511:0] block_in;
  logic         ov [4];
  logic         ir [4];
  logic         bz [4];
  logic [255:0] dg [4];

  int           n_tests = 0;
  int           n_fail  = 0;
  int           ov_at [4];
  int           ir_at [4];
  logic [255:0] dg_at [4];

  int           acc_cnt [4] = '{default: 0};
  int           hs_cnt  [4] = '{default: 0};
  logic [255:0] hs_last [4] = '{default: '0};
  logic [255:0] hs_prev [4] = '{default: '0};

  sha2_256_core_param #(.ROUNDS_PER_CYCLE(1), .SUPPORT_224(1'b1)) u_r1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]), .block_in(block_in),
    .first_block(first_block), .last_block(last_block), .mode_224(mode_224),
    .out_valid(ov[0]), .out_ready(out_ready), .digest_out(dg[0]), .busy(bz[0]));
  sha2_256_core_param #(.ROUNDS_PER_CYCLE(2), .SUPPORT_224(1'b1)) u_r2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]), .block_in(block_in),
    .first_block(first_block), .last_block(last_block), .mode_224(mode_224),
    .out_valid(ov[1]), .out_ready(out_ready), .digest_out(dg[1]), .busy(bz[1]));
  sha2_256_core_param #(.ROUNDS_PER_CYCLE(4), .SUPPORT_224(1'b1)) u_r4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]), .block_in(block_in),
    .first_block(first_block), .last_block(last_block), .mode_224(mode_224),
    .out_valid(ov[2]), .out_ready(out_ready), .digest_out(dg[2]), .busy(bz[2]));
  sha2_256_core_param #(.ROUNDS_PER_CYCLE(1), .SUPPORT_224(1'b0)) u_n224 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[3]), .block_in(block_in),
    .first_block(first_block), .last_block(last_block), .mode_224(mode_224),
    .out_valid(ov[3]), .out_ready(out_ready), .digest_out(dg[3]), .busy(bz[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Accept/handshake events are decided at the coming posedge; inputs are stable at negedge.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst && in_valid && ir[i]) acc_cnt[i]++;
      if (!rst && ov[i] && out_ready) begin
        hs_prev[i] = hs_last[i];
        hs_last[i] = dg[i];
        hs_cnt[i]++;
      end
    end
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one block for a single edge, then watch all cores for 90 edges.
  task automatic run_block(input logic [511:0] blk, input logic fb, input logic lb, input logic m);
    block_in    = blk;
    first_block = fb;
    last_block  = lb;
    mode_224    = m;
    in_valid    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ov_at[i] = 0;
      ir_at[i] = 0;
      dg_at[i] = '0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 1; c <= 90; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        if (ov[i] && ov_at[i] == 0) begin
          ov_at[i] = c;
          dg_at[i] = dg[i];
        end
        if (ir[i] && ir_at[i] == 0) ir_at[i] = c;
      end
    end
  endtask

  initial begin
    logic         stab [4];
    int           acc0 [4];
    int           hs0  [4];
    int           c;
    rst = 1'b1; in_valid = 1'b0; first_block = 1'b0; last_block = 1'b0;
    mode_224 = 1'b0; out_ready = 1'b1; block_in = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset in_ready[%0d]", i), 256'(ir[i]), 256'd1);
      check($sformatf("reset out_valid[%0d]", i), 256'(ov[i]), 256'd0);
      check($sformatf("reset busy[%0d]", i), 256'(bz[i]), 256'd0);
      check($sformatf("reset digest[%0d]", i), dg[i], 256'd0);
    end
    rst = 1'b0;

    // SHA-256 "abc" at every fold factor
    run_block(BLK_ABC, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abc256 latency[%0d]", i), 256'(ov_at[i]), 256'(LAT[i]));
      check($sformatf("abc256 digest[%0d]", i), dg_at[i], D_ABC256);
    end

    // SHA-224 "abc"; the core without SHA-224 support must still give SHA-256
    run_block(BLK_ABC, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abc224 latency[%0d]", i), 256'(ov_at[i]), 256'(LAT[i]));
      check($sformatf("abc224 digest[%0d]", i), dg_at[i], (i == 3) ? D_ABC256 : D_ABC224);
    end

    // Two-block message; mode_224 on the second block must be ignored
    run_block(BLK_TWO1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("two blk1 no out_valid[%0d]", i), 256'(ov_at[i]), 256'd0);
      check($sformatf("two blk1 in_ready back[%0d]", i), 256'(ir_at[i]), 256'(LAT[i] - 1));
    end
    run_block(BLK_TWO2, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("two blk2 latency[%0d]", i), 256'(ov_at[i]), 256'(LAT[i]));
      check($sformatf("two blk2 digest[%0d]", i), dg_at[i], D_TWO);
    end

    // Backpressure on the empty-string digest
    out_ready = 1'b0;
    block_in = BLK_EMPTY; first_block = 1'b1; last_block = 1'b1; mode_224 = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    c = 0;
    while (!ov[0] && c < 100) begin
      @(posedge clk); #1;
      c++;
    end
    check("bp out_valid reached", 256'(ov[0]), 256'd1);
    for (int i = 0; i < 4; i++) stab[i] = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++)
        if (!(ov[i] === 1'b1 && ir[i] === 1'b0 && dg[i] === D_EMPTY)) stab[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) check($sformatf("bp stable[%0d]", i), 256'(stab[i]), 256'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("bp out_valid falls[%0d]", i), 256'(ov[i]), 256'd0);
      check($sformatf("bp in_ready back[%0d]", i), 256'(ir[i]), 256'd1);
      check($sformatf("bp digest kept[%0d]", i), dg[i], D_EMPTY);
    end
    repeat (3) @(posedge clk);
    #1;

    // Reset while the R=1 core is at round 30
    out_ready = 1'b0;
    block_in = BLK_ABC; first_block = 1'b1; last_block = 1'b1; mode_224 = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("midreset out_valid[%0d]", i), 256'(ov[i]), 256'd0);
      check($sformatf("midreset in_ready[%0d]", i), 256'(ir[i]), 256'd1);
      check($sformatf("midreset digest[%0d]", i), dg[i], 256'd0);
    end
    out_ready = 1'b1;
    run_block(BLK_ABC, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("post-reset latency[%0d]", i), 256'(ov_at[i]), 256'(LAT[i]));
      check($sformatf("post-reset digest[%0d]", i), dg_at[i], D_ABC256);
    end

    // in_valid held through OUT: next block waits for the output handshake
    for (int i = 0; i < 4; i++) begin
      acc0[i] = acc_cnt[i];
      hs0[i]  = hs_cnt[i];
    end
    out_ready = 1'b0;
    block_in = BLK_ABC; first_block = 1'b1; last_block = 1'b1; mode_224 = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    block_in = BLK_EMPTY;
    repeat (70) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold in OUT out_valid[%0d]", i), 256'(ov[i]), 256'd1);
      check($sformatf("hold in OUT in_ready[%0d]", i), 256'(ir[i]), 256'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold accepts[%0d]", i), 256'(acc_cnt[i] - acc0[i]), 256'd2);
      check($sformatf("hold handshakes[%0d]", i), 256'(hs_cnt[i] - hs0[i]), 256'd2);
      check($sformatf("hold digest A[%0d]", i), hs_prev[i], D_ABC256);
      check($sformatf("hold digest B[%0d]", i), hs_last[i], D_EMPTY);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
